// File: rtl/acc_register_file_pkg.sv
// -----------------------------------------------------------------------------
// acc_register_file_pkg
//   Processor-wide datapath constants shared by the register file and its
//   users.
//   DATA_WIDTH : width of every general register and of the accumulator
//   ADDR_WIDTH : register address width
//   NUM_REGS   : number of general registers (2**ADDR_WIDTH)
//   reg_addr_t : register address type
// -----------------------------------------------------------------------------
package acc_register_file_pkg;

  localparam int unsigned DATA_WIDTH = 4;
  localparam int unsigned ADDR_WIDTH = 2;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

endpackage : acc_register_file_pkg

// File: rtl/acc_register_file_rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
//   One asynchronous read port of the register file: selects a register from
//   the stored array and, when enabled, forwards the in-flight write data if
//   the write targets the same register.
//   regs_i        : flattened register array (entry i = register i)
//   read_addr_i   : register to read
//   bypass_vld_i  : a write is being presented this cycle (reset already gated)
//   write_addr_i  : register being written
//   write_data_i  : data being written
//   read_data_o   : combinational read result
// -----------------------------------------------------------------------------
module rf_read_port #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned NUM_REGS   = 2 ** ADDR_WIDTH,
  parameter bit          BYPASS_EN  = 1'b1
) (
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_i,
  input  logic [ADDR_WIDTH-1:0]               read_addr_i,
  input  logic                                bypass_vld_i,
  input  logic [ADDR_WIDTH-1:0]               write_addr_i,
  input  logic [DATA_WIDTH-1:0]               write_data_i,
  output logic [DATA_WIDTH-1:0]               read_data_o
);

  if (BYPASS_EN) begin : g_bypass
    // NOTE: read_data_o is given its stored-value default before the
    // conditional override, so every path assigns it and no latch is inferred.
    always_comb begin
      read_data_o = regs_i[read_addr_i];
      if (bypass_vld_i && (read_addr_i == write_addr_i)) begin
        read_data_o = write_data_i;
      end
    end
  end else begin : g_no_bypass
    logic unused_bypass;
    assign unused_bypass = bypass_vld_i ^ (^write_addr_i) ^ (^write_data_i);
    assign read_data_o   = regs_i[read_addr_i];
  end

endmodule : rf_read_port

// File: rtl/acc_register_file.sv
// -----------------------------------------------------------------------------
// acc_register_file
//   Four general registers plus an accumulator for the 4-bit datapath.
//   clk              : rising-edge clock
//   reset            : asynchronous active-low clear of all state
//   write_enable     : register write strobe
//   acc_write_enable : accumulator write strobe
//   write_addr       : register to write
//   write_data       : register write data
//   acc_in           : accumulator write data
//   read_addr1/2     : read port addresses
//   read_data1/2     : combinational read data (with write-through bypass)
//   acc_out          : registered accumulator value
// -----------------------------------------------------------------------------
module acc_register_file #(
  parameter int unsigned DATA_WIDTH = acc_register_file_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = acc_register_file_pkg::ADDR_WIDTH,
  parameter bit          BYPASS_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic                  acc_write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] acc_in,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic [DATA_WIDTH-1:0] acc_out
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [DATA_WIDTH-1:0]               acc_q, acc_d;
  logic                                bypass_vld;

  // Forwarding is suppressed while in reset so all read ports show zero.
  assign bypass_vld = reset & write_enable;

  always_comb begin
    regs_d = regs_q;
    if (write_enable) begin
      regs_d[write_addr] = write_data;
    end
  end

  assign acc_d = acc_write_enable ? acc_in : acc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  // NOTE: the array is small and must read as zero straight out of reset,
  // so it is cleared by the asynchronous reset like ordinary flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '0;
      acc_q  <= '0;
    end else begin
      regs_q <= regs_d;
      acc_q  <= acc_d;
    end
  end

  assign acc_out = acc_q;

  rf_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BYPASS_EN  (BYPASS_EN)
  ) u_read_port1 (
    .regs_i       (regs_q),
    .read_addr_i  (read_addr1),
    .bypass_vld_i (bypass_vld),
    .write_addr_i (write_addr),
    .write_data_i (write_data),
    .read_data_o  (read_data1)
  );

  rf_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BYPASS_EN  (BYPASS_EN)
  ) u_read_port2 (
    .regs_i       (regs_q),
    .read_addr_i  (read_addr2),
    .bypass_vld_i (bypass_vld),
    .write_addr_i (write_addr),
    .write_data_i (write_data),
    .read_data_o  (read_data2)
  );

endmodule : acc_register_file

// File: tb/tb_acc_register_file.sv
// -----------------------------------------------------------------------------
// tb_acc_register_file
//   Directed, table-driven bench for acc_register_file. Each table row is
//   applied after a falling edge, its expected pre-edge outputs are compared,
//   and then one rising edge commits it. Hand-written sequences cover reset
//   entry/exit mid-cycle.
// -----------------------------------------------------------------------------
module tb_acc_register_file;
  import acc_register_file_pkg::*;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef struct packed {
    logic      we;
    logic      awe;
    reg_addr_t wa;
    data_t     wd;
    data_t     ai;
    reg_addr_t ra1;
    reg_addr_t ra2;
    data_t     e1;
    data_t     e2;
    data_t     ea;
  } vec_t;

  localparam int NVEC = 13;

  logic      clk = 1'b0;
  logic      reset;
  logic      write_enable, acc_write_enable;
  reg_addr_t write_addr, read_addr1, read_addr2;
  data_t     write_data, acc_in;
  data_t     read_data1, read_data2, acc_out;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs [NVEC];

  acc_register_file dut (
    .clk              (clk),
    .reset            (reset),
    .write_enable     (write_enable),
    .acc_write_enable (acc_write_enable),
    .write_addr       (write_addr),
    .write_data       (write_data),
    .acc_in           (acc_in),
    .read_addr1       (read_addr1),
    .read_addr2       (read_addr2),
    .read_data1       (read_data1),
    .read_data2       (read_data2),
    .acc_out          (acc_out)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input data_t act, input data_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic awe, input reg_addr_t wa,
                       input data_t wd, input data_t ai,
                       input reg_addr_t ra1, input reg_addr_t ra2);
    write_enable     = we;
    acc_write_enable = awe;
    write_addr       = wa;
    write_data       = wd;
    acc_in           = ai;
    read_addr1       = ra1;
    read_addr2       = ra2;
  endtask

  initial begin
    //                we    awe   wa    wd     ai     ra1   ra2   e1     e2     ea
    vecs[0]  = '{1'b1, 1'b1, 2'd1, 4'hA, 4'hC, 2'd1, 2'd0, 4'hA, 4'h0, 4'h0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 2'd1, 2'd1, 4'hA, 4'hA, 4'hC};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h3, 2'd0, 2'd1, 4'h0, 4'hA, 4'hC};
    vecs[3]  = '{1'b1, 1'b0, 2'd2, 4'h3, 4'h0, 2'd2, 2'd2, 4'h3, 4'h3, 4'hC};
    vecs[4]  = '{1'b0, 1'b0, 2'd2, 4'hE, 4'h0, 2'd2, 2'd1, 4'h3, 4'hA, 4'hC};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 4'h5, 4'h0, 2'd3, 2'd2, 4'h0, 4'h3, 4'hC};
    vecs[6]  = '{1'b1, 1'b0, 2'd3, 4'hF, 4'h0, 2'd0, 2'd1, 4'h5, 4'hA, 4'hC};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 2'd0, 2'd3, 4'h5, 4'hF, 4'hC};
    vecs[8]  = '{1'b1, 1'b1, 2'd2, 4'h6, 4'h9, 2'd1, 2'd3, 4'hA, 4'hF, 4'hC};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 2'd2, 2'd0, 4'h6, 4'h5, 4'h9};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 2'd3, 2'd1, 4'hF, 4'hA, 4'h9};
    vecs[11] = '{1'b1, 1'b0, 2'd1, 4'h7, 4'h0, 2'd0, 2'd1, 4'h5, 4'h7, 4'h9};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 2'd1, 2'd2, 4'h7, 4'h6, 4'h9};

    // Reset from time zero with writes requested: bypass must stay off.
    reset = 1'b0;
    drive(1'b1, 1'b1, 2'd0, 4'hF, 4'hF, 2'd0, 2'd0);
    #1;
    check("reset rd1 no bypass", read_data1, 4'h0);
    check("reset rd2 no bypass", read_data2, 4'h0);
    check("reset acc", acc_out, 4'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 2'd0, 2'd0);
    #1;
    check("post-reset R0 unwritten", read_data1, 4'h0);
    check("post-reset acc unwritten", acc_out, 4'h0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].awe, vecs[i].wa, vecs[i].wd, vecs[i].ai,
            vecs[i].ra1, vecs[i].ra2);
      #1;
      check($sformatf("vec%0d rd1", i), read_data1, vecs[i].e1);
      check($sformatf("vec%0d rd2", i), read_data2, vecs[i].e2);
      check($sformatf("vec%0d acc", i), acc_out, vecs[i].ea);
      @(posedge clk);
    end

    // Load R1=A, acc=C, then assert reset mid-cycle.
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd1, 4'hA, 4'hC, 2'd1, 2'd1);
    @(posedge clk);
    #3;
    drive(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 2'd1, 2'd1);
    #1;
    check("preload R1", read_data1, 4'hA);
    check("preload acc", acc_out, 4'hC);
    reset = 1'b0;
    #1;
    check("async reset rd1", read_data1, 4'h0);
    check("async reset rd2", read_data2, 4'h0);
    check("async reset acc", acc_out, 4'h0);
    // Writes held across an edge during reset are ignored.
    drive(1'b1, 1'b1, 2'd1, 4'h9, 4'h9, 2'd1, 2'd1);
    #1;
    check("reset bypass suppressed", read_data1, 4'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 2'd0, 2'd0);
    for (int r = 0; r < 4; r++) begin
      read_addr1 = reg_addr_t'(r);
      read_addr2 = reg_addr_t'(3 - r);
      #1;
      check($sformatf("released R%0d p1", r), read_data1, 4'h0);
      check($sformatf("released R%0d p2", 3 - r), read_data2, 4'h0);
    end
    check("released acc", acc_out, 4'h0);

    // First edge after release commits writes again.
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd3, 4'h4, 4'h2, 2'd0, 2'd0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 2'd3, 2'd1);
    #1;
    check("resume write R3", read_data1, 4'h4);
    check("resume R1 untouched", read_data2, 4'h0);
    check("resume acc", acc_out, 4'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_acc_register_file
